// File: rtl/acc_alu.sv
// acc_alu: multi-cycle accumulator ALU for the register-file accumulator write-back path.
// Define ACC_ALU_MULDIV_EN to build the iterative MUL/DIV datapath; otherwise MUL/DIV report illegal.
module acc_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             lacc,
    output logic [WIDTH-1:0] acc,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             illegal
);
    localparam int M = WIDTH - 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;

    logic [1:0]     r_state;
    logic [2:0]     r_op;
    logic [M:0]     r_a, r_b, r_acc;
    logic           r_z, r_n, r_c, r_v, r_busy, r_done, r_ill;
    logic [WIDTH:0] w_sum, w_dif, w_shl;
    logic [M:0]     w_res;
    logic           w_c, w_v, w_ill;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};
    assign w_dif = {1'b0, r_a} - {1'b0, r_b};
    assign w_shl = {1'b0, r_a} << r_b[3:0];

    // Ops that reach RUN without a single-cycle implementation are flagged illegal.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (r_op)
            3'b000: begin
                w_res = w_sum[M:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_a[M] == r_b[M]) && (w_sum[M] != r_a[M]);
            end
            3'b001: begin
                w_res = w_dif[M:0];
                w_c   = w_dif[WIDTH];
                w_v   = (r_a[M] != r_b[M]) && (w_dif[M] != r_a[M]);
            end
            3'b010: w_res = r_a & r_b;
            3'b011: w_res = r_a | r_b;
            3'b100: w_res = r_a ^ r_b;
            3'b101: begin
                w_res = w_shl[M:0];
                w_c   = w_shl[WIDTH];
            end
            default: w_ill = 1'b1;
        endcase
    end

`ifdef ACC_ALU_MULDIV_EN
    localparam logic [1:0] S_ITER = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p, w_pn;
    logic [WIDTH:0]     w_madd, w_rs, w_df;

    // r_p holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    assign w_madd = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, (r_p[0] ? r_a : {WIDTH{1'b0}})};
    assign w_rs   = {r_p[2*WIDTH-1:WIDTH], r_p[M]};
    assign w_df   = w_rs - {1'b0, r_b};
    assign w_pn   = r_op[0] ? {(w_df[WIDTH] ? w_rs[M:0] : w_df[M:0]), r_p[WIDTH-2:0], ~w_df[WIDTH]}
                            : {w_madd, r_p[M:1]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ill   <= 1'b0;
`ifdef ACC_ALU_MULDIV_EN
            r_cnt   <= '0;
            r_p     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_ill  <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_op   <= op;
                    r_a    <= opa;
                    r_b    <= opb;
                    r_busy <= 1'b1;
`ifdef ACC_ALU_MULDIV_EN
                    if (op[2:1] == 2'b11) begin
                        r_state <= S_ITER;
                        r_cnt   <= '0;
                        r_p     <= {{WIDTH{1'b0}}, (op[0] ? opa : opb)};
                    end else
`endif
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_acc   <= w_res;
                    r_z     <= !w_ill && (w_res == '0);
                    r_n     <= w_res[M];
                    r_c     <= w_c;
                    r_v     <= w_v;
                    r_ill   <= w_ill;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
`ifdef ACC_ALU_MULDIV_EN
                S_ITER: begin
                    r_p   <= w_pn;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_acc   <= w_pn[M:0];
                        r_z     <= (w_pn[M:0] == '0);
                        r_n     <= w_pn[M];
                        r_c     <= !r_op[0] && (|w_pn[2*WIDTH-1:WIDTH]);
                        r_v     <= r_op[0] && (r_b == '0);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign lacc    = r_done;
    assign acc     = r_acc;
    assign z       = r_z;
    assign n       = r_n;
    assign c       = r_c;
    assign v       = r_v;
    assign illegal = r_ill;
endmodule

// File: tb/tb_acc_alu.sv
// tb_acc_alu: directed plus randomized checks of acc_alu against an arithmetic reference model.
module tb_acc_alu;
    logic        clk, rst, start;
    logic [2:0]  op;
    logic [15:0] opa, opb, acc;
    logic        busy, done, lacc, z, n, c, v, illegal;
    int          checks = 0;
    int          errors = 0;
`ifdef ACC_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    acc_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .lacc(lacc), .acc(acc),
        .z(z), .n(n), .c(c), .v(v), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {illegal, v, c, n, z, acc}.
    function automatic logic [20:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        int unsigned     ua, ub;
        longint unsigned p;
        int              sa, sb, ss;
        logic [15:0]     r;
        logic            cf, vf, il;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        r = '0; cf = 1'b0; vf = 1'b0; il = 1'b0; p = 0; ss = 0;
        case (o)
            3'd0: begin
                p = longint'(ua) + longint'(ub); r = p[15:0]; cf = p > 65535;
                ss = sa + sb; vf = ss > 32767 || ss < -32768;
            end
            3'd1: begin
                r = a - b; cf = ua < ub;
                ss = sa - sb; vf = ss > 32767 || ss < -32768;
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin p = longint'(ua) << b[3:0]; r = p[15:0]; cf = p[16]; end
            3'd6: if (MD) begin p = longint'(ua) * longint'(ub); r = p[15:0]; cf = p > 65535; end
                  else il = 1'b1;
            default: if (MD) begin
                         if (ub == 0) begin r = 16'hFFFF; vf = 1'b1; end
                         else r = 16'(ua / ub);
                     end else il = 1'b1;
        endcase
        return {il, vf, cf, r[15], (!il && r == 16'h0000), r};
    endfunction

    function automatic int lat(input logic [2:0] o);
        return (MD && o[2:1] == 2'b11) ? 16 : 1;
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [20:0] e;
        int          k;
        e = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); opa = 16'($urandom); opb = 16'($urandom);
        check("busy_after_accept", busy, 1);
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (done) break;
            start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        check("latency", k, lat(o));
        check("acc", acc, e[15:0]);
        check("flags_ivcnz", {illegal, v, c, n, z}, e[20:16]);
        check("lacc_eq_done", lacc, 1);
        check("busy_at_done", busy, 0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("acc_hold", acc, e[15:0]);
        check("flags_hold", {v, c, n, z}, e[19:16]);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [15:0] ra, rb;
        rst = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0;
        #1;
        check("rst_outputs", {busy, done, lacc, illegal, z, n, c, v}, 8'h00);
        check("rst_acc", acc, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_op(3'd0, 16'h7FFF, 16'h0001);
        check("add_const", {acc, n, v, c, z}, {16'h8000, 4'b1100});
        do_op(3'd1, 16'h0005, 16'h0006);
        check("sub_const", {acc, c, n, v}, {16'hFFFF, 3'b110});
        do_op(3'd5, 16'h8001, 16'h0001);
        check("lsl_const", {acc, c}, {16'h0002, 1'b1});
        do_op(3'd5, 16'h8001, 16'h0000);
        do_op(3'd6, 16'h0100, 16'h0100);
        do_op(3'd6, 16'h0003, 16'h0007);
        check("mul_or_illegal", {acc, illegal}, MD ? {16'h0015, 1'b0} : {16'h0000, 1'b0});
        do_op(3'd7, 16'd100, 16'd7);
        do_op(3'd7, 16'd5, 16'd0);
        do_op(3'd2, 16'hF0F0, 16'h0FF0);
        do_op(3'd3, 16'hF000, 16'h000F);
        do_op(3'd4, 16'hFFFF, 16'hFFFF);
        do_op(3'd0, 16'hFFFF, 16'h0001);

        // Reset in the middle of an operation.
        do_op(3'd1, 16'h1234, 16'h0034);
        @(negedge clk);
        start = 1'b1; op = MD ? 3'd6 : 3'd0; opa = 16'd3; opb = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (MD ? 7 : 0) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_outputs", {busy, done, lacc, illegal, z, n, c, v}, 8'h00);
        check("abort_acc", acc, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        repeat (MD ? 18 : 3) begin
            @(posedge clk); #1;
            check("abort_no_done", {done, busy}, 2'b00);
        end
        do_op(3'd0, 16'd2, 16'd3);
        check("after_rst_add", acc, 16'd5);

        // start held high: a RUN op completes every two cycles.
        @(negedge clk);
        start = 1'b1; op = 3'd0; opa = 16'd1; opb = 16'd1;
        @(posedge clk); #1;
        check("b2b_busy", busy, 1);
        @(posedge clk); #1;
        check("b2b_done1", {done, acc}, {1'b1, 16'd2});
        opa = 16'd5;
        @(posedge clk); #1;
        check("b2b_gap", {done, busy}, 2'b01);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_done2", {done, acc}, {1'b1, 16'd6});
        @(posedge clk); #1;
        check("b2b_idle", {done, busy}, 2'b00);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 5))
                0: rb[3:0] = 4'h0;
                1: rb = 16'h0000;
                2: ra = 16'h8000;
                default: ;
            endcase
            do_op(ro, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_alu.md
# acc_alu

Multi-cycle accumulator ALU feeding the register file's accumulator write-back path. It takes the register-file read value as operand A and a memory or immediate value as operand B. It computes the selected operation and presents the result on `acc` with a one-cycle `lacc` write-back strobe. Single-cycle logic ops complete in one cycle; multiply and divide are iterative.

## Interface
- `WIDTH`, 16, datapath width; the iteration count equals `WIDTH`.
- `clk` in 1: clock; all state changes on posedge.
- `rst` in 1: asynchronous active-low reset.
- `start` in 1: request. Sampled only in IDLE.
- `op` in 3: operation code, latched on accept.
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 LSL by `opb[3:0]`.
  - 110 MUL (unsigned, low half).
  - 111 DIV (unsigned quotient).
- `opa` in WIDTH: operand A (register-file `out`), latched on accept.
- `opb` in WIDTH: operand B (load / sign-extended immediate), latched on accept.
- `busy` out 1: high from the accept edge until the result edge.
- `done` out 1: one-cycle pulse; the result is valid.
- `lacc` out 1: write-back strobe to the register file; identical to `done`.
- `acc` out WIDTH: result register; holds its value between operations.
- `z`, `n`, `c`, `v` out 1 each: flags.
- `illegal` out 1: one-cycle pulse with `done` when the op is not compiled in.

## Operation
- FSM states: IDLE, RUN, ITER.
  - IDLE + `start`: latch `op`, `opa`, `opb`; `busy`←1. Go to ITER (MUL/DIV with the feature built in, counter←0), else RUN.
  - RUN: write `acc` and flags; pulse `done`/`lacc`; `busy`←0; go to IDLE.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV) step per cycle. On the step where counter = WIDTH-1, write `acc` and flags, pulse `done`/`lacc`, clear `busy`, and go to IDLE.
- `start` outside IDLE is ignored and is not queued.
- Arithmetic is modulo 2^WIDTH; operands are unsigned except for `v`.
- Flags update only on a `done` edge and otherwise hold.
  - `z` = (result == 0).
  - `n` = result MSB.
  - `c`:
    - ADD: carry-out.
    - SUB: borrow (`opa` < `opb`).
    - LSL: last bit shifted out, 0 when the shift amount is 0.
    - MUL: high half nonzero.
    - All other ops: 0.
  - `v`:
    - ADD/SUB: two's-complement overflow.
    - DIV: divisor = 0.
    - All other ops: 0.
- DIV by zero still runs WIDTH cycles and returns `acc` = all ones with `v` = 1.
- Reset values: `acc` = 0, `z`/`n`/`c`/`v` = 0, `busy` = 0, `done` = 0, `lacc` = 0, `illegal` = 0, state = IDLE, counter = 0.
- Reset mid-operation: the operation is abandoned immediately, no `done` is produced, and all outputs take their reset values.

## Timing
- Accept at edge k.
  - RUN ops: result and `done` at edge k+1.
  - ITER ops: result and `done` at edge k+WIDTH (k+16 by default).
- `done`/`lacc` are registered and high for exactly one cycle.
- `busy` is high from edge k until the result edge.
- Back-to-back: the FSM is in IDLE during the `done` cycle, so `start` held high is accepted at the next edge. One RUN op therefore completes every 2 cycles.
- Operands may change after the accept edge without affecting the result.

## Configuration
- `ACC_ALU_MULDIV_EN` defined: MUL/DIV are iterative as above and `illegal` never asserts.
- `ACC_ALU_MULDIV_EN` undefined:
  - No ITER datapath or counter is synthesized.
  - Ops 110/111 take the RUN path with `acc` = 0, all flags = 0, and `illegal` pulsed with `done` at k+1.

## Test plan
- ADD `opa`=0x7FFF, `opb`=0x0001 -> `acc`=0x8000, n=1, v=1, c=0, z=0; `done`/`lacc` high exactly at edge k+1.
- SUB 0x0005−0x0006 -> `acc`=0xFFFF, c=1, n=1, v=0. Then LSL 0x8001 by 1 -> `acc`=0x0002, c=1.
- MUL 0x0100×0x0100 -> `acc`=0x0000, z=1, c=1, `done` at k+16.
  - MUL 0x0003×0x0007 -> 0x0015, c=0.
  - `start` pulses during ITER are ignored (exactly one `done`).
- DIV 100/7 -> `acc`=14, v=0. DIV 5/0 -> `acc`=0xFFFF, v=1, `done` at k+16.
- `rst` low at the 8th ITER cycle -> `busy`=0, `acc`=0, flags 0, and no `done` for the aborted op. After release, ADD 2+3 -> 5.
- Build without `ACC_ALU_MULDIV_EN`, op 110 with 3×7 -> `acc`=0, `illegal`=1 and `done`=1 at k+1, `busy` low afterwards.
